// File: rtl/classificador_digito.sv
// classificador_digito: scans the per-template difference matrices through an
// external read mux. It accumulates one sum per digit and reports the digit
// with the smallest sum using an inicio/ocupado/pronto handshake.
// Optional build macro: CLASSIFICADOR_PODA_EN. When it is defined, a digit
// after the first is abandoned as soon as its running sum exceeds the best
// sum found so far. The result is unchanged; only the latency varies.
module classificador_digito #(
  parameter int N_DIGITOS = 10,
  parameter int LADO      = 11,
  parameter int LARG_SOMA = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inicio,
  input  logic [7:0]           diff_pixel,
  output logic [3:0]           sel_digito,
  output logic [3:0]           sel_linha,
  output logic [3:0]           sel_coluna,
  output logic                 ocupado,
  output logic                 pronto,
  output logic [3:0]           digito,
  output logic [LARG_SOMA-1:0] menor_soma
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACUM    = 2'd1,
    COMPARA = 2'd2,
    FIM     = 2'd3
  } estado_t;

  localparam logic [3:0] ULTIMO_IDX    = 4'(LADO - 1);
  localparam logic [3:0] ULTIMO_DIGITO = 4'(N_DIGITOS - 1);

  estado_t              estado_r, estado_s;
  logic [LARG_SOMA-1:0] soma_r, soma_s;
  logic [LARG_SOMA-1:0] min_r, min_s;
  logic [3:0]           melhor_r, melhor_s;
  logic [3:0]           sel_digito_s, sel_linha_s, sel_coluna_s;
  logic                 ocupado_s, pronto_s;
  logic [3:0]           digito_s;
  logic [LARG_SOMA-1:0] menor_soma_s;

  // The parameter constraint keeps this addition from overflowing.
  logic [LARG_SOMA-1:0] soma_prox_s;
  // Strict compare: on a tie the lower digit (seen first) is kept.
  logic                 novo_min_s;

  assign soma_prox_s = soma_r + LARG_SOMA'(diff_pixel);
  assign novo_min_s  = (soma_r < min_r);

  // Next-state and next-value logic for the scan FSM and its datapath.
  always_comb begin
    estado_s     = estado_r;
    soma_s       = soma_r;
    min_s        = min_r;
    melhor_s     = melhor_r;
    sel_digito_s = sel_digito;
    sel_linha_s  = sel_linha;
    sel_coluna_s = sel_coluna;
    ocupado_s    = ocupado;
    pronto_s     = 1'b0;
    digito_s     = digito;
    menor_soma_s = menor_soma;

    case (estado_r)
      IDLE: begin
        if (inicio) begin
          sel_digito_s = 4'd0;
          sel_linha_s  = 4'd0;
          sel_coluna_s = 4'd0;
          soma_s       = {LARG_SOMA{1'b0}};
          min_s        = {LARG_SOMA{1'b1}};
          ocupado_s    = 1'b1;
          estado_s     = ACUM;
        end else begin
          estado_s = IDLE;
        end
      end

      ACUM: begin
        // The pixel addressed by the registered selects is added this cycle.
        soma_s = soma_prox_s;
`ifdef CLASSIFICADOR_PODA_EN
        // Once the running sum exceeds the best sum, this digit cannot win.
        if ((sel_digito != 4'd0) && (soma_prox_s > min_r)) begin
          estado_s = COMPARA;
        end else if (sel_coluna != ULTIMO_IDX) begin
          sel_coluna_s = sel_coluna + 4'd1;
        end else if (sel_linha != ULTIMO_IDX) begin
          sel_coluna_s = 4'd0;
          sel_linha_s  = sel_linha + 4'd1;
        end else begin
          estado_s = COMPARA;
        end
`else
        if (sel_coluna != ULTIMO_IDX) begin
          sel_coluna_s = sel_coluna + 4'd1;
        end else if (sel_linha != ULTIMO_IDX) begin
          sel_coluna_s = 4'd0;
          sel_linha_s  = sel_linha + 4'd1;
        end else begin
          estado_s = COMPARA;
        end
`endif
      end

      COMPARA: begin
        if (novo_min_s) begin
          min_s    = soma_r;
          melhor_s = sel_digito;
        end else begin
          min_s    = min_r;
          melhor_s = melhor_r;
        end
        if (sel_digito == ULTIMO_DIGITO) begin
          // Results are registered on entry to FIM, so pronto shows during FIM.
          digito_s     = novo_min_s ? sel_digito : melhor_r;
          menor_soma_s = novo_min_s ? soma_r : min_r;
          pronto_s     = 1'b1;
          ocupado_s    = 1'b0;
          estado_s     = FIM;
        end else begin
          sel_digito_s = sel_digito + 4'd1;
          sel_linha_s  = 4'd0;
          sel_coluna_s = 4'd0;
          soma_s       = {LARG_SOMA{1'b0}};
          estado_s     = ACUM;
        end
      end

      FIM: begin
        estado_s = IDLE;
      end

      default: begin
        estado_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_r   <= IDLE;
      soma_r     <= {LARG_SOMA{1'b0}};
      min_r      <= {LARG_SOMA{1'b1}};
      melhor_r   <= 4'd0;
      sel_digito <= 4'd0;
      sel_linha  <= 4'd0;
      sel_coluna <= 4'd0;
      ocupado    <= 1'b0;
      pronto     <= 1'b0;
      digito     <= 4'd0;
      menor_soma <= {LARG_SOMA{1'b0}};
    end else begin
      estado_r   <= estado_s;
      soma_r     <= soma_s;
      min_r      <= min_s;
      melhor_r   <= melhor_s;
      sel_digito <= sel_digito_s;
      sel_linha  <= sel_linha_s;
      sel_coluna <= sel_coluna_s;
      ocupado    <= ocupado_s;
      pronto     <= pronto_s;
      digito     <= digito_s;
      menor_soma <= menor_soma_s;
    end
  end

endmodule

// File: tb/tb_classificador_digito.sv
// Table-driven bench for classificador_digito with directed corner sequences.
module tb_classificador_digito;

  logic        clk;
  logic        reset;
  logic        inicio;
  logic [7:0]  diff_pixel;
  logic [3:0]  sel_digito, sel_linha, sel_coluna;
  logic        ocupado, pronto;
  logic [3:0]  digito;
  logic [14:0] menor_soma;

  classificador_digito dut (
    .clk        (clk),
    .reset      (reset),
    .inicio     (inicio),
    .diff_pixel (diff_pixel),
    .sel_digito (sel_digito),
    .sel_linha  (sel_linha),
    .sel_coluna (sel_coluna),
    .ocupado    (ocupado),
    .pronto     (pronto),
    .digito     (digito),
    .menor_soma (menor_soma)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  base;
    logic [3:0]  esp_dig;
    logic [7:0]  esp_val;
    logic        padrao;
    logic [3:0]  exp_digito;
    logic [14:0] exp_soma;
    int          exp_lat;
  } vetor_t;

`ifdef CLASSIFICADOR_PODA_EN
  localparam int LAT_V1 = 861;
  localparam int LAT_V3 = 141;
  localparam int LAT_V5 = 921;
`else
  localparam int LAT_V1 = 1221;
  localparam int LAT_V3 = 1221;
  localparam int LAT_V5 = 1221;
`endif

  // Difference-matrix model: one special digit, all others a constant.
  logic [7:0] base_v, esp_v;
  logic [3:0] esp_d;
  logic       padrao_v;

  // Combinational read mux model feeding the DUT.
  always_comb begin
    if (sel_digito == esp_d) begin
      if (padrao_v) diff_pixel = 8'(sel_linha) + 8'(sel_coluna);
      else          diff_pixel = esp_v;
    end else begin
      diff_pixel = base_v;
    end
  end

  int checks = 0;
  int errors = 0;
  int ciclo  = 0;
  vetor_t vetores[6];

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nome, got, exp);
    end
  endtask

  task automatic passo;
    @(posedge clk);
    #1;
    ciclo++;
  endtask

  task automatic carregar(input vetor_t v);
    base_v   = v.base;
    esp_d    = v.esp_dig;
    esp_v    = v.esp_val;
    padrao_v = v.padrao;
  endtask

  task automatic esperar_pronto;
    while (!pronto && ciclo < 3000) passo();
  endtask

  // Starts a scan at cycle 0 and checks the full result for one vector.
  task automatic rodar(input vetor_t v, input int idx);
    carregar(v);
    inicio = 1'b1;
    ciclo  = 0;
    passo();
    inicio = 1'b0;
    chk($sformatf("v%0d_ocupado_c1", idx), 32'(ocupado), 32'd1);
    chk($sformatf("v%0d_sel_c1", idx), {20'd0, sel_digito, sel_linha, sel_coluna}, 32'd0);
    while (ciclo < 12) passo();
    chk($sformatf("v%0d_sel_c12", idx), {20'd0, sel_digito, sel_linha, sel_coluna}, 32'h010);
    esperar_pronto();
    chk($sformatf("v%0d_latencia", idx), 32'(ciclo), 32'(v.exp_lat));
    chk($sformatf("v%0d_digito", idx), 32'(digito), 32'(v.exp_digito));
    chk($sformatf("v%0d_menor_soma", idx), 32'(menor_soma), 32'(v.exp_soma));
    chk($sformatf("v%0d_ocupado_fim", idx), 32'(ocupado), 32'd0);
    passo();
    chk($sformatf("v%0d_pronto_pulso", idx), 32'(pronto), 32'd0);
    chk($sformatf("v%0d_digito_mantido", idx), 32'(digito), 32'(v.exp_digito));
  endtask

  initial begin
    int contagem_pronto;

    vetores[0] = '{8'd0,   4'd0, 8'd0,   1'b0, 4'd0, 15'd0,     1221};
    vetores[1] = '{8'd1,   4'd6, 8'd0,   1'b0, 4'd6, 15'd0,     LAT_V1};
    vetores[2] = '{8'd255, 4'd9, 8'd254, 1'b0, 4'd9, 15'd30734, 1221};
    vetores[3] = '{8'd1,   4'd0, 8'd0,   1'b0, 4'd0, 15'd0,     LAT_V3};
    vetores[4] = '{8'd5,   4'd3, 8'd5,   1'b0, 4'd0, 15'd605,   1221};
    vetores[5] = '{8'd20,  4'd4, 8'd0,   1'b1, 4'd4, 15'd1210,  LAT_V5};

    carregar(vetores[0]);
    inicio = 1'b0;
    reset  = 1'b1;
    passo();
    passo();
    reset = 1'b0;
    chk("reset_ocupado", 32'(ocupado), 32'd0);
    chk("reset_pronto", 32'(pronto), 32'd0);
    chk("reset_digito", 32'(digito), 32'd0);
    chk("reset_menor_soma", 32'(menor_soma), 32'd0);
    chk("reset_sel", {20'd0, sel_digito, sel_linha, sel_coluna}, 32'd0);
    passo();

    for (int i = 0; i < 6; i++) begin
      rodar(vetores[i], i);
      passo();
    end

    // inicio during a scan is ignored; inicio during pronto is ignored too.
    carregar(vetores[0]);
    inicio = 1'b1;
    ciclo  = 0;
    passo();
    inicio = 1'b0;
    while (ciclo < 50) passo();
    inicio = 1'b1;
    passo();
    inicio = 1'b0;
    chk("repulso_ocupado_c51", 32'(ocupado), 32'd1);
    esperar_pronto();
    chk("repulso_latencia1", 32'(ciclo), 32'd1221);
    inicio = 1'b1;
    passo();
    chk("repulso_ignorado_c1222", 32'(ocupado), 32'd0);
    passo();
    inicio = 1'b0;
    chk("repulso_aceito_c1223", 32'(ocupado), 32'd1);
    esperar_pronto();
    chk("repulso_latencia2", 32'(ciclo), 32'd2443);
    passo();

    // Reset in the middle of a scan drops the scan and the previous result.
    rodar(vetores[2], 20);
    passo();
    carregar(vetores[2]);
    inicio = 1'b1;
    ciclo  = 0;
    passo();
    inicio = 1'b0;
    while (ciclo < 600) passo();
    chk("reset_meio_digito_mantido", 32'(digito), 32'd9);
    reset = 1'b1;
    passo();
    reset = 1'b0;
    chk("reset_meio_ocupado", 32'(ocupado), 32'd0);
    chk("reset_meio_digito", 32'(digito), 32'd0);
    chk("reset_meio_menor_soma", 32'(menor_soma), 32'd0);
    chk("reset_meio_pronto", 32'(pronto), 32'd0);
    contagem_pronto = 0;
    for (int k = 0; k < 700; k++) begin
      passo();
      if (pronto) contagem_pronto++;
    end
    chk("reset_meio_sem_pronto", 32'(contagem_pronto), 32'd0);
    rodar(vetores[2], 21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
